// File: rtl/mac_accumulator_16bits.sv
// Multiply-accumulate back end: sums unsigned products of a vector and presents the total
// with term count and overflow flag. Define MAC_ACC_SATURATE_EN to clamp instead of wrapping.
module mac_accumulator_16bits #(
  parameter int unsigned PROD_W = 32,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] product,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  result,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [ACC_W:0]   sum;

  assign in_ready  = (state_q != StHold);
  assign out_valid = (state_q == StHold);
  assign accept    = in_valid && in_ready;
  // One extra bit captures the carry out of the accumulator.
  assign sum       = {1'b0, acc_q} + (ACC_W + 1)'(product);

  assign result   = acc_q;
  assign count    = cnt_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = ACC_W'(product);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
`ifdef MAC_ACC_SATURATE_EN
          acc_d = (sum[ACC_W] || ovf_q) ? '1 : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d = ovf_q | sum[ACC_W];
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = in_last ? StHold : StAcc;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator_16bits.sv
// Scoreboard bench for mac_accumulator_16bits: driver queues expected vector totals,
// a negedge monitor compares them whenever out_valid is high.
module tb_mac_accumulator_16bits;

  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned CNT_W  = 16;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PROD_W-1:0] product = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [ACC_W-1:0]  result;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              out_valid;
  logic              out_ready = 1'b1;

  mac_accumulator_16bits #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .product  (product),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .result   (result),
    .count    (count),
    .overflow (overflow),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [31:0] p;
    int          gap;
  } term_t;

  exp_t  exp_q[$];
  term_t vec[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: a vector's outcome follows from the plain arithmetic total of its terms.
  function automatic void push_exp(int n, logic [63:0] total);
    exp_t e;
    e.ovf = (total > ACC_MAX);
`ifdef MAC_ACC_SATURATE_EN
    e.res = e.ovf ? ACC_W'(ACC_MAX) : ACC_W'(total);
`else
    e.res = ACC_W'(total);
`endif
    e.cnt = (n > 65535) ? CNT_W'(65535) : CNT_W'(n);
    exp_q.push_back(e);
  endfunction

  // Monitor: check every cycle the result is presented; retire on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("result", 64'(result), 64'(exp_q[0].res));
        chk("count", 64'(count), 64'(exp_q[0].cnt));
        chk("overflow", 64'(overflow), 64'(exp_q[0].ovf));
        chk("in_ready_in_hold", 64'(in_ready), 64'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_term(input logic [31:0] p, input logic last, input int gap);
    int n;
    repeat (gap) begin
      product = $urandom;
      @(posedge clk);
      #1;
    end
    product  = p;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    product  = $urandom;
  endtask

  task automatic send_vec();
    logic [63:0] total = 64'd0;
    int n = 0;
    foreach (vec[i]) begin
      send_term(vec[i].p, (i == vec.size() - 1), vec[i].gap);
      total += 64'(vec[i].p);
      n++;
    end
    push_exp(n, total);
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] p, input int n);
    vec.delete();
    for (int i = 0; i < n; i++) vec.push_back('{p: p, gap: 0});
  endtask

  initial begin
    int n;
    #1;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_in_ready", 64'(in_ready), 64'd1);
    chk("init_result", 64'(result), 64'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Single term 0x2771 * 0x0F67.
    vec.delete();
    vec.push_back('{p: 32'd39812471, gap: 0});
    send_vec();

    // Three terms with a gap, result stalled for five cycles.
    ready_mode = 2;
    vec.delete();
    vec.push_back('{p: 32'd100, gap: 0});
    vec.push_back('{p: 32'd200, gap: 3});
    vec.push_back('{p: 32'd300, gap: 0});
    send_vec();
    repeat (5) @(posedge clk);
    #1;
    ready_mode = 0;

    // Largest sum that still fits, then one term past it.
    fill(32'hFFFF_FFFF, 256);
    send_vec();
    fill(32'hFFFF_FFFF, 257);
    send_vec();

    // Reset mid-vector discards partial sum.
    send_term(32'd5, 1'b0, 0);
    send_term(32'd7, 1'b0, 0);
    do_reset();
    vec.delete();
    vec.push_back('{p: 32'd9, gap: 0});
    send_vec();

    // Back-to-back with a term waiting through the handshake.
    vec.delete();
    vec.push_back('{p: 32'd4, gap: 0});
    send_vec();

    // Reset while a result is pending.
    ready_mode = 2;
    send_vec();
    do_reset();
    ready_mode = 1;

    for (int v = 0; v < 25; v++) begin
      vec.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        vec.push_back('{p: ((v % 5) == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255)) : $urandom,
                        gap: $urandom_range(0, 2)});
      end
      send_vec();
    end

    ready_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator_16bits.md
MAC_ACCUMULATOR_16BITS -- requirements
Module: mac_accumulator_16bits

Interface
REQ-001 The module SHALL have parameter PROD_W, default 32, giving the width of the incoming unsigned product from the 16x16 multiplier.
REQ-002 The module SHALL have parameter ACC_W, default 40, giving the accumulator width (ACC_W >= PROD_W).
REQ-003 The module SHALL have parameter CNT_W, default 16, giving the term-counter width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port product, input, PROD_W bits: the unsigned multiplier output, i.e. the term to accumulate.
REQ-007 The module SHALL have port in_valid, input, 1 bit: product is valid this cycle.
REQ-008 The module SHALL have port in_last, input, 1 bit: the current term is the final term of the vector; it is sampled only when a term is accepted.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the module can accept a term.
REQ-010 The module SHALL have port result, output, ACC_W bits: the accumulated dot-product sum.
REQ-011 The module SHALL have port count, output, CNT_W bits: the number of terms in result.
REQ-012 The module SHALL have port overflow, output, 1 bit: the sum exceeded 2^ACC_W-1 during the vector.
REQ-013 The module SHALL have port out_valid, output, 1 bit: result, count and overflow are valid.
REQ-014 The module SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.

Function
REQ-015 The module SHALL implement an FSM with states IDLE, ACC and HOLD.
REQ-016 A term SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-018 A term accepted in IDLE SHALL load acc = zero-extended product and cnt = 1, with the overflow flag cleared.
REQ-019 A term accepted in ACC SHALL update acc = acc + product, modulo 2^ACC_W, and cnt = cnt + 1, saturating at 2^CNT_W-1.
REQ-020 On a carry out of bit ACC_W-1, the overflow flag SHALL be set and SHALL remain set (sticky) until the next vector starts.
REQ-021 A term accepted with in_last=0 SHALL move the FSM to ACC.
REQ-022 A term accepted with in_last=1 SHALL move the FSM to HOLD, from either IDLE or ACC.
REQ-023 A single-term vector (IDLE with in_last=1) SHALL be legal.
REQ-024 The last term SHALL be included in result.
REQ-025 out_valid SHALL rise on the edge that accepts the last term, giving a latency of 1 cycle from the last term to out_valid=1.
REQ-026 In HOLD, result, count and overflow SHALL be held stable, and out_valid SHALL remain 1, until out_valid && out_ready.
REQ-027 On the handshake edge (out_valid && out_ready), the FSM SHALL go to IDLE and out_valid SHALL go to 0; the next term is acceptable on the following cycle.
REQ-028 In ACC with in_valid=0, acc, cnt and the FSM state SHALL hold indefinitely; gaps between terms are allowed.
REQ-029 in_valid while in_ready=0 SHALL be ignored; the upstream holds the term.
REQ-030 out_ready outside HOLD SHALL have no effect.
REQ-031 result, count and overflow SHALL be driven directly from registers, with no combinational path from product to any output.

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE, result=0, count=0, overflow=0 and out_valid=0.
REQ-033 in_ready SHALL be 1 during and immediately after rst.
REQ-034 rst asserted mid-vector (in ACC or HOLD) SHALL discard the partial sum and any pending result.
REQ-035 The first accepted term after rst is deasserted SHALL start a new vector.

Configuration
REQ-036 When macro MAC_ACC_SATURATE_EN is defined, an addition that would exceed 2^ACC_W-1 SHALL clamp acc to 2^ACC_W-1, set overflow, and keep acc clamped for the rest of the vector.
REQ-037 When MAC_ACC_SATURATE_EN is undefined, the accumulator SHALL wrap modulo 2^ACC_W and overflow SHALL still be set.

Verification
REQ-038 Single term: product=39812471 (0x2771*0x0F67) with in_last=1 -> the next cycle gives out_valid=1, result=39812471, count=1, overflow=0.
REQ-039 Three terms 100, 200 (with a 3-cycle in_valid gap), then 300 with last -> result=600, count=3; out_ready held 0 for 5 cycles -> out_valid and outputs stable and in_ready=0 throughout.
REQ-040 No overflow at the limit: 256 terms of 0xFFFFFFFF -> result=0xFFFFFFFF00, count=256, overflow=0.
REQ-041 Overflow: 257 terms of 0xFFFFFFFF without MAC_ACC_SATURATE_EN -> result=0x00FFFFFEFF, overflow=1; with MAC_ACC_SATURATE_EN -> result=0xFFFFFFFFFF, overflow=1.
REQ-042 Reset mid-vector: terms 5 and 7 accepted, rst pulsed, then 9 with last -> result=9, count=1, overflow=0.
REQ-043 Back-to-back: the out_ready handshake edge is followed on the next cycle by a term 4 with last -> in_ready=1 on that cycle and result=4, count=1.
